// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants and types for the message front end and compressor.
package sha1_pkg;
  localparam int SHA1_WORD_W = 32;
  localparam int SHA1_BLK_W  = 512;
  localparam logic [7:0] SHA1_PAD_BYTE = 8'h80;

  localparam logic [31:0] SHA1_H0 = 32'h67452301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
  localparam logic [31:0] SHA1_H3 = 32'h10325476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

  typedef enum logic {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } sha1_pad_state_e;
endpackage

// File: rtl/sha1_pad_word.sv
// Replaces the bytes after the valid ones in a final message word with 0x80 then zeros.
module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [SHA1_WORD_W-1:0] in_data,
  input  logic [2:0]             nbytes,
  output logic [SHA1_WORD_W-1:0] out_word
);

  always_comb begin
    case (nbytes)
      3'd0:    out_word = {SHA1_PAD_BYTE, 24'h0};
      3'd1:    out_word = {in_data[31:24], SHA1_PAD_BYTE, 16'h0};
      3'd2:    out_word = {in_data[31:16], SHA1_PAD_BYTE, 8'h0};
      3'd3:    out_word = {in_data[31:8], SHA1_PAD_BYTE};
      default: out_word = in_data;
    endcase
  end

endmodule

// File: rtl/sha1_msg_pad.sv
// SHA-1 message padder: packs 32-bit words into 512-bit blocks, adds the 0x80 marker,
// zero fill and 64-bit bit length, and flags first/final blocks of each message.
module sha1_msg_pad
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SHA1_WORD_W-1:0] in_data,
  input  logic                   in_vld,
  input  logic                   in_last,
  input  logic [2:0]             in_bytes,
  output logic                   in_rdy,
  output logic [SHA1_BLK_W-1:0]  blk_data,
  output logic                   blk_vld,
  input  logic                   blk_rdy,
  output logic                   blk_first,
  output logic                   blk_final
);

  localparam logic [31:0] MARK_WORD = {SHA1_PAD_BYTE, 24'h0};

  sha1_pad_state_e    state_q, state_d;
  logic [0:15][31:0]  w_q, w_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               mark_q, mark_d;
  logic               first_q, first_d;
  logic               final_q, final_d;

  logic [2:0]         nb;
  logic [5:0]         add_bits;
  logic [LEN_W-1:0]   len_nxt;
  logic [63:0]        len64_nxt;
  logic [63:0]        len64_cur;
  logic [4:0]         pos;
  logic [31:0]        padded;

  assign nb        = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign add_bits  = in_last ? {nb, 3'b000} : 6'd32;
  assign len_nxt   = cnt_q + LEN_W'(add_bits);
  assign len64_nxt = 64'(len_nxt);
  assign len64_cur = 64'(cnt_q);
  // A full last word pushes the marker into the following word slot.
  assign pos       = (nb == 3'd4) ? ({1'b0, idx_q} + 5'd1) : {1'b0, idx_q};

  sha1_pad_word u_pad_word (
    .in_data  (in_data),
    .nbytes   (nb),
    .out_word (padded)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    mark_d  = mark_q;
    first_d = first_q;
    final_d = final_q;
    in_rdy  = (state_q == ACCUM);

    case (state_q)
      ACCUM: begin
        if (in_vld) begin
          cnt_d = len_nxt;
          if (!in_last) begin
            w_d[idx_q] = in_data;
            idx_d      = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_d = SEND;
              final_d = 1'b0;
            end
          end else begin
            w_d[idx_q] = padded;
            if (nb == 3'd4 && pos <= 5'd15) w_d[pos[3:0]] = MARK_WORD;
            if (pos <= 5'd13) begin
              w_d[14] = len64_nxt[63:32];
              w_d[15] = len64_nxt[31:0];
              final_d = 1'b1;
            end else begin
              final_d = 1'b0;
              pend_d  = 1'b1;
              mark_d  = (pos == 5'd16);
            end
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (blk_rdy) begin
          w_d = '0;
          if (pend_q) begin
            w_d[0]  = mark_q ? MARK_WORD : 32'h0;
            w_d[14] = len64_cur[63:32];
            w_d[15] = len64_cur[31:0];
            final_d = 1'b1;
            pend_d  = 1'b0;
            mark_d  = 1'b0;
            first_d = 1'b0;
          end else begin
            idx_d   = 4'd0;
            state_d = ACCUM;
            if (final_q) begin
              first_d = 1'b1;
              final_d = 1'b0;
              cnt_d   = '0;
            end else begin
              first_d = 1'b0;
            end
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      w_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      mark_q  <= 1'b0;
      first_q <= 1'b1;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mark_q  <= mark_d;
      first_q <= first_d;
      final_q <= final_d;
    end
  end

  assign blk_data  = w_q;
  assign blk_vld   = (state_q == SEND);
  assign blk_first = first_q;
  assign blk_final = final_q;

endmodule

// File: tb/tb_sha1_msg_pad.sv
// Randomized bench for sha1_msg_pad against a byte-level FIPS 180-4 padding model.
module tb_sha1_msg_pad;

  logic         clk;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_vld;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         in_rdy;
  logic [511:0] blk_data;
  logic         blk_vld;
  logic         blk_rdy;
  logic         blk_first;
  logic         blk_final;

  int checks = 0;
  int errors = 0;

  logic [511:0] exp_q[$];

  sha1_msg_pad #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .in_rdy    (in_rdy),
    .blk_data  (blk_data),
    .blk_vld   (blk_vld),
    .blk_rdy   (blk_rdy),
    .blk_first (blk_first),
    .blk_final (blk_final)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Reference: pad the byte string as the standard describes, then cut into 64-byte blocks.
  task automatic build_exp(input logic [7:0] msg[$]);
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] v;
    p = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bl >> (8 * i)));
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      v = '0;
      for (int j = 0; j < 64; j++) v = {v[503:0], p[64 * b + j]};
      exp_q.push_back(v);
    end
  endtask

  task automatic run_msg(input logic [7:0] msg[$], input bit rnd, input int stall_n);
    logic [31:0] wd[$];
    logic [2:0]  wb[$];
    logic [31:0] d;
    int L, nw, lastb, wi, k, nb, stalls;
    bit done;
    L = msg.size();
    nw = (L + 3) / 4;
    if (nw == 0) nw = 1;
    else if (L % 4 == 0 && rnd && $urandom_range(0, 1) == 1) nw++;
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < L) d[31 - 8 * b -: 8] = msg[4 * w + b];
      wd.push_back(d);
      wb.push_back(rnd ? 3'($urandom_range(0, 7)) : 3'd4);
    end
    lastb = L - 4 * (nw - 1);
    if (lastb == 4 && rnd) wb[nw - 1] = 3'(4 + $urandom_range(0, 3));
    else wb[nw - 1] = 3'(lastb);
    build_exp(msg);
    nb = exp_q.size();
    wi = 0; k = 0; stalls = 0; done = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (wi < nw && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_vld   = 1'b1;
        in_data  = wd[wi];
        in_bytes = wb[wi];
        in_last  = (wi == nw - 1);
      end else begin
        in_vld   = 1'b0;
        in_data  = $urandom;
        in_bytes = 3'($urandom_range(0, 7));
        in_last  = $urandom_range(0, 1) == 1;
      end
      if (stalls < stall_n) blk_rdy = 1'b0;
      else blk_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (blk_vld) begin
        chk("in_rdy_send", 512'(in_rdy), 512'(0));
        if (k >= nb) begin
          chk("extra_block", 512'(blk_vld), 512'(0));
          done = 1;
        end else begin
          chk("blk_data", blk_data, exp_q[k]);
          chk("blk_first", 512'(blk_first), 512'(k == 0));
          chk("blk_final", 512'(blk_final), 512'(k == nb - 1));
          if (blk_rdy) k++;
          else stalls++;
        end
      end else begin
        chk("in_rdy_accum", 512'(in_rdy), 512'(1));
      end
      if (in_vld && in_rdy) wi++;
      if (wi == nw && k == nb) done = 1;
    end
    if (!done) chk("timeout", 512'(0), 512'(1));
    @(negedge clk);
    in_vld  = 1'b0;
    blk_rdy = 1'b0;
    #1;
    chk("idle_vld", 512'(blk_vld), 512'(0));
    chk("idle_first", 512'(blk_first), 512'(1));
  endtask

  initial begin
    logic [7:0] m[$];
    string s;
    rst = 1'b1; in_vld = 1'b0; in_last = 1'b0; in_bytes = 3'd0; in_data = '0; blk_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", 512'(blk_vld), 512'(0));
    chk("rst_data", blk_data, 512'(0));
    chk("rst_first", 512'(blk_first), 512'(1));
    chk("rst_final", 512'(blk_final), 512'(0));
    chk("rst_in_rdy", 512'(in_rdy), 512'(1));
    rst = 1'b0;

    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 0, 0);
    m.delete();
    run_msg(m, 0, 0);
    m.delete();
    for (int i = 0; i < 55; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 0);
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    m.delete();
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    run_msg(m, 0, 0);
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 0);
    m.delete();
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
    run_msg(m, 0, 5);

    // Abort a partial message with reset; the next message must start clean.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_vld = 1'b1; in_last = 1'b0; in_bytes = 3'd4; in_data = $urandom;
    end
    @(negedge clk);
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_vld", 512'(blk_vld), 512'(0));
    chk("midrst_data", blk_data, 512'(0));
    chk("midrst_first", 512'(blk_first), 512'(1));
    @(negedge clk);
    rst = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 0, 0);

    for (int t = 0; t < 40; t++) begin
      m.delete();
      for (int i = 0; i < $urandom_range(0, 150); i++) m.push_back(8'($urandom));
      run_msg(m, 1, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
